// File: rtl/demux_capture_pkg.sv
// Shared types and constants for the bit-serial to parallel-word capture block.
// Latency: n/a (types only).
// Backpressure: n/a.
package demux_capture_pkg;

    localparam int K_DEF    = 64;
    localparam int SELW_DEF = $clog2(K_DEF);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Completion pattern for a default-width write mask.
    localparam logic [K_DEF-1:0] ALL_ONES = {K_DEF{1'b1}};

endpackage

// File: rtl/demux_ptr_counter.sv
// Wrapping write pointer for auto-increment steering; clr beats inc.
// Latency: new value visible one cycle after inc/clr.
// Backpressure: none; the caller gates inc with the accept condition.
module demux_ptr_counter
    import demux_capture_pkg::*;
#(
    parameter int W = SELW_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/demux_1x64_capture.sv
// Steers one bit per beat into a K-bit word; presents the word once every position is written.
// Latency: last accepted beat at cycle N gives out_valid at N+1; optional out_parity via DEMUX_CAPTURE_PARITY_EN.
// Backpressure: in_ready drops while a full word waits for out_ready; no pass-through on handshake.
module demux_1x64_capture
    import demux_capture_pkg::*;
#(
    parameter int K    = K_DEF,
    parameter int SELW = $clog2(K)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            auto_inc,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_bit,
    input  logic [SELW-1:0] in_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [K-1:0]    out_data,
`ifdef DEMUX_CAPTURE_PARITY_EN
    output logic            out_parity,
`endif
    output logic [K-1:0]    wr_mask
);

    state_t          state;
    state_t          state_nxt;
    logic [K-1:0]    data_nxt;
    logic [K-1:0]    mask_nxt;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] addr;
    logic            accept;
    logic            word_taken;

    assign in_ready   = (state == FILL);
    assign out_valid  = (state == HOLD);
    assign accept     = in_valid & in_ready & ~clear;
    assign word_taken = out_valid & out_ready & ~clear;
    assign addr       = auto_inc ? ptr : in_sel;

    demux_ptr_counter #(.W(SELW)) u_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear | word_taken),
        .inc   (accept & auto_inc),
        .cnt   (ptr)
    );

    // Completion is judged on the post-write mask, so rewrites never advance it.
    always_comb begin
        state_nxt = state;
        data_nxt  = out_data;
        mask_nxt  = wr_mask;
        if (clear) begin
            state_nxt = FILL;
            data_nxt  = '0;
            mask_nxt  = '0;
        end else if (accept) begin
            data_nxt[addr] = in_bit;
            mask_nxt[addr] = 1'b1;
            if (&mask_nxt) begin
                state_nxt = HOLD;
            end
        end else if (word_taken) begin
            state_nxt = FILL;
            data_nxt  = '0;
            mask_nxt  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FILL;
            out_data <= '0;
            wr_mask  <= '0;
        end else begin
            state    <= state_nxt;
            out_data <= data_nxt;
            wr_mask  <= mask_nxt;
        end
    end

`ifdef DEMUX_CAPTURE_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else begin
            out_parity <= ^data_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_demux_1x64_capture.sv
// Randomised scoreboard bench for demux_1x64_capture against a bit-array reference model.
module tb_demux_1x64_capture;

    localparam int K = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          auto_inc = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_bit = 1'b0;
    logic [5:0]    in_sel = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [K-1:0]  out_data;
    logic [K-1:0]  wr_mask;
`ifdef DEMUX_CAPTURE_PARITY_EN
    logic          out_parity;
`endif

    demux_1x64_capture dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .auto_inc  (auto_inc),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef DEMUX_CAPTURE_PARITY_EN
        .out_parity(out_parity),
`endif
        .wr_mask   (wr_mask)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: the word being assembled, which positions are written, the pointer, and whether a word is waiting.
    logic [K-1:0] mdata = '0;
    logic [K-1:0] mmask = '0;
    int           mptr = 0;
    bit           mhold = 1'b0;
    logic [K-1:0] expq[$];

    task automatic chk(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdata = '0;
        mmask = '0;
        mptr  = 0;
        mhold = 1'b0;
    endtask

    // One clock: apply the behavioural rules to the inputs present at the edge, then move off the edge.
    task automatic tick();
        int a;
        @(posedge clk);
        if (rst_n) begin
            if (clear) begin
                if (mhold) void'(expq.pop_back());
                model_reset();
            end else if (!mhold) begin
                if (in_valid) begin
                    a = auto_inc ? mptr : int'(in_sel);
                    mdata[a] = in_bit;
                    mmask[a] = 1'b1;
                    if (auto_inc) mptr = (mptr + 1) % K;
                    if (mmask == {K{1'b1}}) begin
                        mhold = 1'b1;
                        expq.push_back(mdata);
                    end
                end
            end else if (out_ready) begin
                model_reset();
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic beat(input logic b, input logic [5:0] s, input logic ai);
        clear    = 1'b0;
        in_valid = 1'b1;
        in_bit   = b;
        in_sel   = s;
        auto_inc = ai;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic fill_auto(input logic [K-1:0] w);
        for (int i = 0; i < K; i++) beat(w[i], 6'($urandom), 1'b1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Cycle monitor: state-visible outputs against the model, and the word scoreboard on each handshake.
    always @(negedge clk) begin
        logic [K-1:0] e;
        if (rst_n) begin
            chk("in_ready", K'(in_ready), K'(!mhold));
            chk("out_valid", K'(out_valid), K'(mhold));
            chk("out_data", out_data, mdata);
            chk("wr_mask", wr_mask, mmask);
`ifdef DEMUX_CAPTURE_PARITY_EN
            chk("out_parity", K'(out_parity), K'(^mdata));
`endif
            if (out_valid && out_ready && !clear) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %h expected none", out_data);
                end else begin
                    e = expq.pop_front();
                    chk("word", out_data, e);
                    chk("word_mask", wr_mask, {K{1'b1}});
                end
            end
        end
    end

    initial begin
        logic [K-1:0] w;
        logic [K-1:0] alt;
        int           perm[K];
        int           j;
        int           tmp;

        // Reset values before any clock edge.
        #1;
        chk("rst_data", out_data, '0);
        chk("rst_mask", wr_mask, '0);
        chk("rst_in_ready", K'(in_ready), K'(1));
        chk("rst_out_valid", K'(out_valid), K'(0));
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Auto-increment fill, held under backpressure, then taken.
        w = 64'hA5A5_0F0F_DEAD_BEEF;
        fill_auto(w);
        chk("fill_valid", K'(out_valid), K'(1));
        chk("fill_ready", K'(in_ready), K'(0));
        chk("fill_data", out_data, w);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("fill_stable", out_data, w);
        end
        handshake();
        chk("after_take_valid", K'(out_valid), K'(0));
        chk("after_take_data", out_data, '0);

        // Random permutation of explicit selects.
        for (int i = 0; i < K; i++) perm[i] = i;
        for (int i = K - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        alt = 64'hAAAA_AAAA_AAAA_AAAA;
        for (int i = 0; i < K; i++) beat(perm[i][0], 6'(perm[i]), 1'b0);
        chk("perm_data", out_data, alt);
        handshake();

        // Same again with a duplicate write of 0 to index 5 before the last beat.
        if (perm[K-1] == 5) begin
            perm[K-1] = perm[0]; perm[0] = 5;
        end
        for (int i = 0; i < K - 1; i++) beat(perm[i][0], 6'(perm[i]), 1'b0);
        chk("dup_pop_before", K'($countones(wr_mask)), K'(63));
        beat(1'b0, 6'd5, 1'b0);
        chk("dup_pop_after", K'($countones(wr_mask)), K'(63));
        chk("dup_bit5", K'(out_data[5]), K'(0));
        chk("dup_valid", K'(out_valid), K'(0));
        beat(perm[K-1][0], 6'(perm[K-1]), 1'b0);
        w = 64'hAAAA_AAAA_AAAA_AA8A;
        chk("dup_data", out_data, w);
        handshake();

        // in_valid held through HOLD; next word must begin at position 0.
        w = {$urandom, $urandom};
        fill_auto(w);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        auto_inc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_data", out_data, w);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("bp_empty_mask", wr_mask, '0);
        for (int i = 0; i < 3; i++) beat(1'b1, 6'd40, 1'b1);
        chk("bp_restart_mask", wr_mask, 64'h7);
        for (int i = 3; i < K; i++) beat(1'($urandom), 6'd40, 1'b1);
        handshake();

        // clear after 30 beats drops the concurrent beat and restarts the word.
        for (int i = 0; i < 30; i++) beat(1'b1, 6'd0, 1'b1);
        clear    = 1'b1;
        in_valid = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_mask", wr_mask, '0);
        chk("clr_data", out_data, '0);
        for (int i = 0; i < K - 1; i++) beat(1'($urandom), 6'd0, 1'b1);
        chk("clr_63_not_valid", K'(out_valid), K'(0));
        beat(1'b1, 6'd0, 1'b1);
        chk("clr_64_valid", K'(out_valid), K'(1));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_hold_valid", K'(out_valid), K'(0));
        chk("clr_hold_ready", K'(in_ready), K'(1));

        // Asynchronous reset in mid-cycle, mid-word.
        for (int i = 0; i < 10; i++) beat(1'b1, 6'd0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        expq.delete();
        chk("arst_data", out_data, '0);
        chk("arst_mask", wr_mask, '0);
        chk("arst_in_ready", K'(in_ready), K'(1));
        chk("arst_out_valid", K'(out_valid), K'(0));
        tick();
        rst_n = 1'b1;
        idle(1);

`ifdef DEMUX_CAPTURE_PARITY_EN
        w = 64'h7;
        fill_auto(w);
        chk("parity_7", K'(out_parity), K'(1));
        handshake();
        w = 64'h3;
        fill_auto(w);
        chk("parity_3", K'(out_parity), K'(0));
        handshake();
`endif

        // Random mix of modes, gaps, backpressure and occasional clears.
        for (int n = 0; n < 3000; n++) begin
            clear     = ($urandom_range(199, 0) == 0);
            in_valid  = ($urandom_range(3, 0) != 0);
            in_bit    = 1'($urandom);
            in_sel    = 6'($urandom);
            auto_inc  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(2, 0) == 0);
            tick();
        end
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(2);
        out_ready = 1'b0;
        chk("queue_drained", K'(expq.size()), K'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_1x64_capture.md
Name: demux_1x64_capture

Overview:
- Sequential 1-to-64 demultiplexer and capture register; the inverse of the 64:1 bit-select mux.
- Accepts one bit per valid/ready beat and steers it into bit position `sel` of a 64-bit word. `sel` comes either from the input or from an internal auto-increment pointer.
- When all 64 positions have been written, it presents the assembled word on an output valid/ready handshake.
- Sits between a bit-serial source and any parallel-word consumer.

Parameters:
- K, 64, number of output bit positions (power of two, >= 2).
- SELW, $clog2(K) = 6, width of the select/pointer.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; flushes the partial word.
- auto_inc  input  1  1: use the internal pointer; 0: use in_sel.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_bit  input  1  data bit.
- in_sel  input  SELW  target bit index, used when auto_inc=0.
- out_valid  output  1  assembled word available.
- out_ready  input  1  consumer accepts the word.
- out_data  output  K  assembled word.
- wr_mask  output  K  positions written in the current word.

Behaviour:
- Reset (rst_n=0, async):
  - state=FILL, out_data=0, wr_mask=0, ptr=0, out_valid=0, in_ready=1.
  - Deassertion is synchronised externally.
- States: FILL, HOLD. All outputs are registered, except in_ready=(state==FILL) and out_valid=(state==HOLD), which decode the state register.
- FILL:
  - Accept when in_valid & in_ready.
  - addr = auto_inc ? ptr : in_sel.
  - Write out_data[addr]<=in_bit and wr_mask[addr]<=1, both visible the next cycle.
  - If auto_inc=1, ptr<=ptr+1, wrapping K-1 -> 0. If auto_inc=0, ptr is unchanged.
  - Rewriting an already-written index overwrites the bit; the mask is unchanged and no error is raised.
  - If the post-write mask is all ones, go to HOLD the next cycle.
  - Latency: the last accepted beat at cycle N gives out_valid=1 at N+1.
- HOLD:
  - in_ready=0; in_valid is ignored.
  - out_data and wr_mask are held stable while out_valid=1 & out_ready=0.
  - On out_valid & out_ready: go to FILL. out_data<=0, wr_mask<=0, ptr<=0.
  - A new beat can be accepted the cycle after the output handshake; there is no same-cycle pass-through.
- clear:
  - Highest synchronous priority, in any state.
  - Next state FILL; out_data, wr_mask and ptr go to 0.
  - A beat presented with clear=1 is dropped. A HOLD word is discarded without handshake.
- auto_inc may change mid-word. The pointer keeps its value and the mask still governs completion.
- Reset mid-word or mid-HOLD returns immediately to the reset values.
- out_ready while in FILL is ignored.

Optional Feature:
- Macro DEMUX_CAPTURE_PARITY_EN.
- Defined:
  - Adds output out_parity (1 bit), registered, equal to the XOR of all out_data bits. It is updated with every write and is valid while out_valid=1.
  - Reset/clear value is 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package demux_capture_pkg:
  - state enum {FILL, HOLD}.
  - Default K/SELW constants.
  - ALL_ONES mask constant helper.
- One natural sub-module, demux_ptr_counter: a SELW-bit wrapping counter with inc/clr inputs.
- The decoder/steering and mask logic stay in the top level.

Test Plan:
1. Reset: drive rst_n=0 mid-cycle -> out_data=0, wr_mask=0, in_ready=1, out_valid=0, without waiting for a clock edge.
2. Auto fill:
   - Stimulus: auto_inc=1, 64 beats in_bit = bit i of 64'hA5A5_0F0F_DEAD_BEEF, out_ready=0.
   - Response: out_valid=1 on the cycle after beat 64; out_data=64'hA5A5_0F0F_DEAD_BEEF; in_ready=0; the word stays stable for 5 cycles.
   - Then out_ready=1 -> FILL next cycle, out_data=0.
3. Random select:
   - Stimulus: auto_inc=0, 64 beats with in_sel a random permutation and in_bit=in_sel[0].
   - Response: out_data=64'hAAAA_AAAA_AAAA_AAAA. A duplicate write to index 5 with bit 0 before completion -> bit 5 = 0 and the mask popcount is unchanged.
4. Backpressure: in_valid held high during HOLD -> no beats consumed, in_ready=0, and the next word starts at ptr=0.
5. Clear:
   - Stimulus: after 30 beats, assert clear with in_valid=1.
   - Response: wr_mask=0, ptr=0, the beat is dropped, and 64 more beats are needed to reach out_valid. clear in HOLD -> out_valid=0 the next cycle.
6. Parity (macro defined): word 64'h0000_0000_0000_0007 -> out_parity=1; word 64'h3 -> out_parity=0; the port is absent when undefined (compile check).
